// File: rtl/pmem_arb_pkg.sv
// Shared types and helpers for the pmem line arbiter and its round-robin picker.
package pmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   // Width of a port index; never narrower than one bit so a 2-port build still has a select.
   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pmem_arbiter_rr_rr_picker.sv
// Round-robin picker: first asserted request at or above rr_ptr, wrapping past the top port.
module rr_picker
   import pmem_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   localparam int IDX_W = idx_w(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     rr_ptr,
   output logic [IDX_W-1:0]     grant,
   output logic                 any_req
);

   // Scan NUM_PORTS candidates starting at rr_ptr; the wrap is an explicit subtract so
   // port counts that are not a power of two never index past the last port.
   always_comb begin
      int idx;
      idx     = 0;
      grant   = '0;
      any_req = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_PORTS) begin
            idx = idx - NUM_PORTS;
         end
         if (!any_req && req[IDX_W'(idx)]) begin
            any_req = 1'b1;
            grant   = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/pmem_arbiter_rr.sv
// N-port round-robin arbiter serialising cache line reads/writebacks onto one pmem port.
module pmem_arbiter_rr
   import pmem_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int LINE_W    = 256,
   parameter int ADDR_W    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        port_read,
   input  logic [NUM_PORTS-1:0]        port_write,
   input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
   input  logic [NUM_PORTS*LINE_W-1:0] port_wdata,
   output logic [NUM_PORTS-1:0]        port_resp,
   output logic [LINE_W-1:0]           port_rdata,
   output logic                        pmem_read,
   output logic                        pmem_write,
   output logic [ADDR_W-1:0]           pmem_address,
   output logic [LINE_W-1:0]           pmem_wdata,
   input  logic [LINE_W-1:0]           pmem_rdata,
   input  logic                        pmem_resp
);

   localparam int IDX_W = idx_w(NUM_PORTS);

   arb_state_t         state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   grant_q;
   logic               op_write;

   logic [NUM_PORTS-1:0] req;
   logic [IDX_W-1:0]     pick;
   logic                 any_req;
   logic [ADDR_W-1:0]    sel_addr;
   logic [LINE_W-1:0]    sel_wdata;
   logic                 sel_write;
   logic [IDX_W-1:0]     ptr_next;

   assign req = port_read | port_write;

   rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .grant   (pick),
      .any_req (any_req)
   );

   // Route the picked client's address, write line and op onto the latch inputs; write wins.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (pick == IDX_W'(i)) begin
            sel_addr  = port_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = port_wdata[i*LINE_W +: LINE_W];
            sel_write = port_write[i];
         end
      end
   end

   assign ptr_next = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);

   // Arbitration FSM with registered pmem and client outputs; reset abandons any in-flight access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         grant_q      <= '0;
         op_write     <= 1'b0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
         port_resp    <= '0;
         port_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               port_resp <= '0;
               if (any_req) begin
                  grant_q      <= pick;
                  op_write     <= sel_write;
                  pmem_address <= sel_addr;
                  pmem_wdata   <= sel_wdata;
                  pmem_write   <= sel_write;
                  pmem_read    <= ~sel_write;
                  state        <= ACCESS;
               end
            end
            ACCESS: begin
               if (pmem_resp) begin
                  if (!op_write) begin
                     port_rdata <= pmem_rdata;
                  end
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
                  port_resp  <= NUM_PORTS'(1) << grant_q;
                  state      <= RESP;
               end
            end
            RESP: begin
               port_resp <= '0;
               rr_ptr    <= ptr_next;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pmem_arbiter_rr.sv
// Self-checking bench for pmem_arbiter_rr: vector table, directed corner sequences, random traffic.
module tb_pmem_arbiter_rr;

   localparam int NP = 3;
   localparam int LW = 256;
   localparam int AW = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NP-1:0]     port_read = '0;
   logic [NP-1:0]     port_write = '0;
   logic [NP*AW-1:0]  port_addr = '0;
   logic [NP*LW-1:0]  port_wdata = '0;
   logic [NP-1:0]     port_resp;
   logic [LW-1:0]     port_rdata;
   logic              pmem_read;
   logic              pmem_write;
   logic [AW-1:0]     pmem_address;
   logic [LW-1:0]     pmem_wdata;
   logic [LW-1:0]     pmem_rdata;
   logic              pmem_resp;

   pmem_arbiter_rr #(.NUM_PORTS(NP), .LINE_W(LW), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .port_read    (port_read),
      .port_write   (port_write),
      .port_addr    (port_addr),
      .port_wdata   (port_wdata),
      .port_resp    (port_resp),
      .port_rdata   (port_rdata),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   int          mem_lat = 3;
   int          mem_cnt = 0;
   bit          mem_fixed_en = 1'b1;
   logic [LW-1:0] mem_fixed = '0;
   logic [LW-1:0] mem_sent = '0;
   logic [LW-1:0] auto_rdata = '0;
   logic        auto_resp = 1'b0;
   logic        man_resp = 1'b0;

   assign pmem_resp  = auto_resp | man_resp;
   assign pmem_rdata = auto_rdata;

   function automatic logic [LW-1:0] mem_fn(input logic [AW-1:0] a);
      return {4{a, ~a}};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         mem_cnt   = 0;
         auto_resp = 1'b0;
      end else if (auto_resp) begin
         auto_resp = 1'b0;
      end else if (pmem_read || pmem_write) begin
         mem_cnt++;
         if (mem_cnt >= mem_lat) begin
            mem_cnt    = 0;
            auto_rdata = mem_fixed_en ? mem_fixed : mem_fn(pmem_address);
            mem_sent   = auto_rdata;
            auto_resp  = 1'b1;
         end
      end else begin
         mem_cnt = 0;
      end
   end

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference model: pointer-based round robin over the set of requesting clients.
   int            m_ptr = 0;
   bit            m_busy = 1'b0;
   int            m_g = 0;
   bit            m_wr = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [LW-1:0] m_rdata = '0;
   bit            prev_active = 1'b0;
   logic [NP-1:0] prev_resp = '0;
   int            just_done = -1;
   int            n_txn = 0;

   task automatic model_reset();
      m_ptr       = 0;
      m_busy      = 1'b0;
      m_rdata     = '0;
      prev_active = 1'b0;
      prev_resp   = '0;
   endtask

   // Advance to the next falling edge and check everything the model can predict there.
   task automatic tick();
      logic [NP-1:0] req;
      logic [NP-1:0] oh;
      logic [LW-1:0] exp;
      int g;
      bit act;
      @(negedge clk);
      just_done = -1;
      act = pmem_read | pmem_write;
      if (!rst) begin
         if (act && !prev_active) begin
            req = port_read | port_write;
            g = -1;
            for (int k = 0; k < NP; k++) begin
               if (g < 0 && req[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
            end
            check("grant_has_request", {255'd0, (g >= 0)}, 256'd1);
            if (g < 0) g = 0;
            m_g    = g;
            m_wr   = port_write[g];
            m_addr = port_addr[g*AW +: AW];
            m_busy = 1'b1;
            check("op_write", pmem_write, m_wr);
            check("op_read", pmem_read, !m_wr);
            check("address", pmem_address, m_addr);
            check("wdata", pmem_wdata, port_wdata[g*LW +: LW]);
         end else if (act) begin
            check("address_stable", pmem_address, m_addr);
         end
         if (port_resp != '0) begin
            oh = '0;
            if (m_busy) oh[m_g] = 1'b1;
            check("resp_onehot", port_resp, oh);
            check("resp_single_cycle", prev_resp, '0);
            if (m_busy) begin
               exp = m_wr ? m_rdata : mem_sent;
               check("rdata", port_rdata, exp);
               m_rdata = exp;
               m_ptr = (m_g + 1) % NP;
               m_busy = 1'b0;
               port_read[m_g]  = 1'b0;
               port_write[m_g] = 1'b0;
               just_done = m_g;
               n_txn++;
            end
         end
      end
      prev_active = act;
      prev_resp   = port_resp;
   endtask

   task automatic wait_resp(output int n);
      tick();
      n = 1;
      while (port_resp == '0 && n < 100) begin
         tick();
         n++;
      end
      if (port_resp == '0) begin
         n_tests++;
         n_fail++;
         $display("FAIL resp_timeout: got no port_resp after %0d cycles, required a pulse", n);
      end
   endtask

   task automatic clear_inputs();
      port_read  = '0;
      port_write = '0;
      port_addr  = '0;
      port_wdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      model_reset();
      tick();
      check("rst_pmem_read", pmem_read, '0);
      check("rst_pmem_write", pmem_write, '0);
      check("rst_pmem_address", pmem_address, '0);
      check("rst_pmem_wdata", pmem_wdata, '0);
      check("rst_port_resp", port_resp, '0);
      check("rst_port_rdata", port_rdata, '0);
      tick();
      rst = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int            port;
      bit            rd;
      bit            wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      int            lat;
      logic [LW-1:0] mem_data;
      bit            exp_wr;
      logic [NP-1:0] exp_resp;
      logic [LW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int g;
      vecs[0] = '{0, 1'b1, 1'b0, 32'h0000_1000, {LW{1'b0}},  3, {32{8'hA5}}, 1'b0, 3'b001, {32{8'hA5}}};
      vecs[1] = '{1, 1'b1, 1'b1, 32'h0000_0040, {32{8'h5A}}, 2, {32{8'hFF}}, 1'b1, 3'b010, {32{8'hA5}}};
      vecs[2] = '{2, 1'b0, 1'b1, 32'h0000_0080, {32{8'h3C}}, 1, {LW{1'b0}},  1'b1, 3'b100, {32{8'hA5}}};
      vecs[3] = '{2, 1'b1, 1'b0, 32'h0000_2000, {LW{1'b0}},  4, {8{32'h0123_4567}}, 1'b0, 3'b100, {8{32'h0123_4567}}};

      do_reset();

      // Single-client transactions from the table.
      for (int v = 0; v < 4; v++) begin
         mem_fixed_en = 1'b1;
         mem_fixed    = vecs[v].mem_data;
         mem_lat      = vecs[v].lat;
         port_read[vecs[v].port]  = vecs[v].rd;
         port_write[vecs[v].port] = vecs[v].wr;
         port_addr[vecs[v].port*AW +: AW]  = vecs[v].addr;
         port_wdata[vecs[v].port*LW +: LW] = vecs[v].wdata;
         tick();
         check("vec_pmem_read", pmem_read, !vecs[v].exp_wr);
         check("vec_pmem_write", pmem_write, vecs[v].exp_wr);
         check("vec_pmem_address", pmem_address, vecs[v].addr);
         check("vec_pmem_wdata", pmem_wdata, vecs[v].wdata);
         wait_resp(n);
         check("vec_latency", n, vecs[v].lat);
         check("vec_port_resp", port_resp, vecs[v].exp_resp);
         check("vec_port_rdata", port_rdata, vecs[v].exp_rdata);
         tick();
         check("vec_resp_dropped", port_resp, '0);
         check("vec_pmem_idle", {pmem_read, pmem_write}, '0);
      end

      // Request dropped mid-access still completes; pmem_resp outside ACCESS is ignored.
      mem_lat = 4;
      port_read[0] = 1'b1;
      port_addr[0 +: AW] = 32'h0000_3000;
      tick();
      port_read[0] = 1'b0;
      wait_resp(n);
      check("drop_port_resp", port_resp, 3'b001);
      man_resp = 1'b1;
      tick();
      tick();
      man_resp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("spurious_no_resp", port_resp, '0);
         check("spurious_no_access", {pmem_read, pmem_write}, '0);
      end

      // Reset during ACCESS: outputs clear at once, no completion, pointer back to 0.
      mem_lat = 20;
      port_read[1] = 1'b1;
      port_addr[AW +: AW] = 32'h0000_4000;
      tick();
      check("rst_mid_granted", pmem_read, 1'b1);
      tick();
      tick();
      #2 rst = 1'b1;
      model_reset();
      #1 check("rst_async_pmem_read", pmem_read, '0);
      check("rst_async_port_resp", port_resp, '0);
      port_read[1] = 1'b0;
      tick();
      check("rst_no_resp_a", port_resp, '0);
      tick();
      check("rst_no_resp_b", port_resp, '0);
      rst = 1'b0;
      mem_lat = 2;
      port_read[0] = 1'b1;
      port_read[1] = 1'b1;
      wait_resp(n);
      check("post_rst_first_grant", port_resp, 3'b001);
      tick();
      wait_resp(n);
      check("post_rst_second_grant", port_resp, 3'b010);
      tick();

      // Wrap: lone port 2 from pointer 0, then ports 0 and 2 together.
      do_reset();
      port_read[2] = 1'b1;
      wait_resp(n);
      check("wrap_lone_port2", port_resp, 3'b100);
      tick();
      port_read[0] = 1'b1;
      port_read[2] = 1'b1;
      wait_resp(n);
      check("wrap_first_port0", port_resp, 3'b001);
      tick();
      wait_resp(n);
      check("wrap_then_port2", port_resp, 3'b100);
      tick();

      // All clients requesting continuously: grants rotate 0,1,2,0,1,2.
      do_reset();
      port_read = '1;
      for (int t = 0; t < 6; t++) begin
         wait_resp(n);
         check("rotate_grant", port_resp, NP'(1) << (t % NP));
         g = just_done;
         tick();
         if (g >= 0) port_read[g] = 1'b1;
      end
      clear_inputs();
      tick();
      tick();

      // Random traffic against the reference model.
      do_reset();
      mem_fixed_en = 1'b0;
      n_txn = 0;
      for (int c = 0; c < 800; c++) begin
         tick();
         mem_lat = $urandom_range(1, 4);
         for (int i = 0; i < NP; i++) begin
            if (i != just_done && !port_read[i] && !port_write[i] && $urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 2))
                  0: port_read[i] = 1'b1;
                  1: port_write[i] = 1'b1;
                  default: begin port_read[i] = 1'b1; port_write[i] = 1'b1; end
               endcase
               port_addr[i*AW +: AW] = $urandom;
               for (int w = 0; w < LW / 32; w++) port_wdata[i*LW + w*32 +: 32] = $urandom;
            end
         end
      end
      check("random_txn_progress", {255'd0, (n_txn >= 40)}, 256'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pmem_arbiter_rr.md
Name: pmem_arbiter_rr

Overview:
Parametrised N-port physical-memory arbiter for the cache hierarchy. It generalises the fixed two-port instruction/data arbiter to NUM_PORTS cache clients with round-robin fairness and configurable line and address widths. It sits between the L1 caches (any mix of read-only and read/write clients) and the single pmem line interface. It serialises line reads and writebacks, one outstanding transaction at a time.

Parameters:
NUM_PORTS, 2, number of cache clients (≥2); port 0 is the lowest index.
LINE_W, 256, cache line width in bits.
ADDR_W, 32, physical address width.

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
port_read  in  NUM_PORTS  per-client line read request; held until matching port_resp
port_write  in  NUM_PORTS  per-client line write request; held until matching port_resp
port_addr  in  NUM_PORTS*ADDR_W  per-client line address; client i uses bits [i*ADDR_W +: ADDR_W]
port_wdata  in  NUM_PORTS*LINE_W  per-client write line; client i uses bits [i*LINE_W +: LINE_W]
port_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse to the granted client
port_rdata  out  LINE_W  read line broadcast to all clients; valid only in the port_resp cycle
pmem_read  out  1  memory line read request
pmem_write  out  1  memory line write request
pmem_address  out  ADDR_W  memory address
pmem_wdata  out  LINE_W  memory write line
pmem_rdata  in  LINE_W  memory read line; valid with pmem_resp
pmem_resp  in  1  memory completion, single-cycle pulse

Behaviour:
- Reset values: every output is 0 (pmem_read, pmem_write, pmem_address, pmem_wdata, port_resp, port_rdata). State = IDLE. Round-robin pointer rr_ptr = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req[i] = port_read[i] | port_write[i].
  - If any req is set, pick the grant g as the first set req[i] scanning from rr_ptr upward, with wrap at NUM_PORTS-1 → 0.
  - Latch g, port_addr[g] → pmem_address, and port_wdata[g] → pmem_wdata.
  - Latch the op: write if port_write[g], else read. If read and write are both set, write wins.
  - Next state is ACCESS.
- ACCESS:
  - pmem_read or pmem_write (registered) is held high with a stable address and data.
  - Client request changes are ignored: a dropped request still completes.
  - On pmem_resp: capture pmem_rdata into port_rdata (reads only; writes leave port_rdata unchanged), deassert pmem_read/pmem_write, and go to RESP.
- RESP:
  - port_resp[g] = 1 for exactly this cycle.
  - rr_ptr <= (g+1) mod NUM_PORTS.
  - Next state is IDLE.
  - Clients must drop or change their request on the edge ending RESP. IDLE therefore never re-grants a stale request.
- Latency:
  - Request visible in IDLE at cycle 0 → pmem_read/pmem_write high at cycle 1.
  - pmem_resp at cycle k → port_resp at cycle k+1.
  - Minimum client round trip = pmem latency + 2 cycles. No back-to-back grants: at least 1 IDLE cycle between transactions.
- pmem_resp while in IDLE or RESP is ignored, with no state change.
- Single requester: granted regardless of rr_ptr.
- All ports requesting continuously: grants rotate 0,1,…,N-1,0 with no starvation. Worst-case wait is (NUM_PORTS-1) transactions.
- Reset asserted mid-ACCESS: all outputs clear immediately (asynchronously), the FSM returns to IDLE, and the in-flight transaction is abandoned with no port_resp.
- NUM_PORTS not a power of two: the wrap uses an explicit compare, not truncation.

Decomposition:
- Package pmem_arb_pkg holds:
  - the arb_state_t enum {IDLE, ACCESS, RESP};
  - the localparam function for the port index width, $clog2(NUM_PORTS) with minimum 1.
- Sub-module rr_picker (combinational, parametrised by NUM_PORTS):
  - inputs: req vector and rr_ptr;
  - outputs: grant index and any_req.
  - It is reused by the planned bus arbiters.

Test Plan:
- Reset, then port 0 reads addr 0x0000_1000 with pmem_resp after 3 cycles and pmem_rdata = 0xA5…A5: pmem_read and pmem_address = 0x1000 one cycle after the request, port_resp = 2'b01 for one cycle with port_rdata = 0xA5…A5, then pmem_read = 0.
- NUM_PORTS=4, all ports read continuously: grant order 0,1,2,3,0,1; exactly one port_resp bit per transaction.
- Port 1 asserts read and write together, addr 0x40, wdata 0x5A…5A: pmem_write = 1 and pmem_read = 0, pmem_wdata = 0x5A…5A; port_resp[1] pulses.
- Port 0 drops port_read during ACCESS: the transaction still completes and port_resp[0] pulses. A spurious pmem_resp in IDLE produces no port_resp.
- rst asserted 2 cycles into ACCESS: pmem_read falls asynchronously and no port_resp occurs. After release, port 0 requests are granted first (rr_ptr = 0).
- NUM_PORTS=3, only port 2 requests, rr_ptr = 0: grant 2; the next simultaneous requests from ports 0 and 2 grant 0 first (wrap check).
